// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding and
// the default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step_counter.sv
// Iteration counter for the divider: synchronous clear, count enable,
// asynchronous active-low reset. Sized by the parent so it never wraps.
module div_step_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Clear has priority over enable so a new operation always starts at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

endmodule

// File: rtl/div_iter_control.sv
// Iterative signed restoring divider, one quotient bit per cycle.
// Sequence: IDLE -> RUN (WIDTH steps) -> FIX (sign correction) -> DONE,
// or IDLE -> ERR on a zero divisor.
// Optional feature: define DIV_REMAINDER_EN to produce the signed remainder;
// without it the remainder output is tied to zero.
module div_iter_control
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    data_result_ready,
  output logic                    data_exception,
  output logic                    busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] step_cnt;
  logic             cnt_clr;
  logic             cnt_en;
  logic             accept;
  logic             div_zero;

  // Working datapath: partial remainder, shifting dividend/quotient, |divisor|
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] dvsr_mag;
  logic             neg_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  logic signed [WIDTH-1:0] quo_r;
`ifdef DIV_REMAINDER_EN
  logic                    neg_r;
  logic signed [WIDTH-1:0] rem_r;
`endif

  // Two's-complement negate when neg is set; used both for magnitudes and sign fix
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign accept   = (state == IDLE) && start;
  assign div_zero = (divisor == '0);
  assign shifted  = {prem, qsh[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvsr_mag};

  div_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (step_cnt)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and counter control; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (div_zero) begin
            state_nxt = ERR;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (step_cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and one restoring step per RUN cycle (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept && !div_zero) begin
      prem     <= '0;
      qsh      <= cond_negate(dividend, dividend[WIDTH-1]);
      dvsr_mag <= cond_negate(divisor, divisor[WIDTH-1]);
      neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`ifdef DIV_REMAINDER_EN
      neg_r    <= dividend[WIDTH-1];
`endif
    end else if (state == RUN) begin
      if (!trial[WIDTH]) begin
        prem <= trial[WIDTH-1:0];
        qsh  <= {qsh[WIDTH-2:0], 1'b1};
      end else begin
        prem <= shifted[WIDTH-1:0];
        qsh  <= {qsh[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result registers: zeroed on divide-by-zero, sign-fixed in FIX, held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_r <= '0;
`ifdef DIV_REMAINDER_EN
      rem_r <= '0;
`endif
    end else if (accept && div_zero) begin
      quo_r <= '0;
`ifdef DIV_REMAINDER_EN
      rem_r <= '0;
`endif
    end else if (state == FIX) begin
      quo_r <= cond_negate(qsh, neg_q);
`ifdef DIV_REMAINDER_EN
      rem_r <= cond_negate(prem, neg_r);
`endif
    end
  end

  assign quotient = quo_r;
`ifdef DIV_REMAINDER_EN
  assign remainder = rem_r;
`else
  assign remainder = '0;
`endif

  assign busy              = (state != IDLE);
  assign data_result_ready = (state == DONE) || (state == ERR);
  assign data_exception    = (state == ERR);

endmodule
